// File: rtl/seg_pair_decoder.sv
// Decodes a two-digit active-low seven-segment pattern pair back to a 0-15 value.
// The pair must be stable for STABLE_CYCLES accepted samples before it is decoded.
module seg_pair_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [6:0] i_seg_tens,
    input  logic [6:0] i_seg_ones,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    output logic [3:0] o_value,
    output logic       o_err,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic [7:0] o_err_count
);
    localparam logic [3:0] N = 4'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, FILTER, DECODE, HOLD} state_t;

    state_t     r_state;
    logic [6:0] r_tens;
    logic [6:0] r_ones;
    logic [3:0] r_count;
    logic [3:0] r_value;
    logic       r_err;
    logic [7:0] r_err_count;

    logic       w_ones_ok;
    logic [3:0] w_ones_val;
    logic       w_tens_ok;
    logic       w_tens_one;
    logic [4:0] w_sum;
    logic       w_pair_err;
    logic       w_match;

    always_comb begin
        w_ones_ok  = 1'b1;
        w_ones_val = 4'd0;
        case (r_ones)
            7'h40: w_ones_val = 4'd0;
            7'h79: w_ones_val = 4'd1;
            7'h24: w_ones_val = 4'd2;
            7'h30: w_ones_val = 4'd3;
            7'h19: w_ones_val = 4'd4;
            7'h12: w_ones_val = 4'd5;
            7'h02: w_ones_val = 4'd6;
            7'h78: w_ones_val = 4'd7;
            7'h00: w_ones_val = 4'd8;
            7'h10: w_ones_val = 4'd9;
            default: w_ones_ok = 1'b0;
        endcase
    end

    // Tens digit is either blank (0) or "1"; anything else is illegal.
    assign w_tens_one = (r_tens == 7'h79);
    assign w_tens_ok  = w_tens_one || (r_tens == 7'h7F);
    assign w_sum      = w_tens_one ? 5'd10 + {1'b0, w_ones_val} : {1'b0, w_ones_val};
    assign w_pair_err = !w_tens_ok || !w_ones_ok || (w_sum > 5'd15);
    assign w_match    = (i_seg_tens == r_tens) && (i_seg_ones == r_ones);

    assign o_in_ready  = (r_state == IDLE) || (r_state == FILTER);
    assign o_out_valid = (r_state == HOLD);
    assign o_value     = r_value;
    assign o_err       = r_err;
    assign o_err_count = r_err_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_tens      <= 7'h7F;
            r_ones      <= 7'h40;
            r_count     <= 4'd0;
            r_value     <= 4'd0;
            r_err       <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            case (r_state)
                IDLE: if (i_in_valid) begin
                    r_tens  <= i_seg_tens;
                    r_ones  <= i_seg_ones;
                    r_count <= 4'd1;
                    r_state <= (N == 4'd1) ? DECODE : FILTER;
                end
                FILTER: begin
                    if (!i_in_valid) begin
                        r_tens  <= 7'h7F;
                        r_ones  <= 7'h40;
                        r_count <= 4'd0;
                        r_state <= IDLE;
                    end else if (w_match) begin
                        r_count <= r_count + 4'd1;
                        if (r_count + 4'd1 == N) r_state <= DECODE;
                    end else begin
                        r_tens  <= i_seg_tens;
                        r_ones  <= i_seg_ones;
                        r_count <= 4'd1;
                    end
                end
                DECODE: begin
                    r_value <= w_pair_err ? 4'd0 : w_sum[3:0];
                    r_err   <= w_pair_err;
                    if (w_pair_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                    r_state <= HOLD;
                end
                HOLD: if (i_out_ready) begin
                    r_count <= 4'd0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seg_pair_decoder.sv
// Bench for seg_pair_decoder: directed scenarios plus randomized traffic,
// checked every cycle against a run-length behavioural model.
module tb_seg_pair_decoder;
    localparam int N = 4;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [6:0] i_seg_tens = 7'h7F;
    logic [6:0] i_seg_ones = 7'h40;
    logic       i_in_valid = 1'b0;
    logic       i_out_ready = 1'b0;
    logic       o_in_ready, o_err, o_out_valid;
    logic [3:0] o_value;
    logic [7:0] o_err_count;

    seg_pair_decoder #(.STABLE_CYCLES(N)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_seg_tens(i_seg_tens), .i_seg_ones(i_seg_ones),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .o_value(o_value), .o_err(o_err),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_err_count(o_err_count)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    logic [6:0] ONES [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Value of a pattern pair by table lookup: tens*10+ones, legal only up to 15.
    task automatic model_decode(input logic [6:0] t, input logic [6:0] o,
                                output logic [3:0] val, output bit e);
        int tv, ov, s;
        tv = (t == 7'h7F) ? 0 : (t == 7'h79) ? 1 : -1;
        ov = -1;
        for (int k = 0; k < 10; k++) if (ONES[k] == o) ov = k;
        s = tv * 10 + ov;
        e = (tv < 0) || (ov < 0) || (s > 15);
        val = e ? 4'd0 : 4'(s);
    endtask

    // Model: length of the current run of identical accepted samples, a pending
    // decode, and a held result waiting for the consumer.
    int         m_run = 0;
    logic [6:0] m_t, m_o;
    bit         m_dec = 0, m_hold = 0, m_err = 0;
    logic [3:0] m_val = 0;
    int         m_ecnt = 0;

    always @(posedge i_clk) begin
        if (i_reset) begin
            m_run = 0; m_dec = 0; m_hold = 0; m_val = 0; m_err = 0; m_ecnt = 0;
        end else if (m_hold) begin
            if (i_out_ready) m_hold = 0;
        end else if (m_dec) begin
            model_decode(m_t, m_o, m_val, m_err);
            if (m_err && m_ecnt < 255) m_ecnt++;
            m_dec = 0; m_hold = 1; m_run = 0;
        end else if (!i_in_valid) begin
            m_run = 0;
        end else begin
            if (m_run > 0 && i_seg_tens == m_t && i_seg_ones == m_o) m_run++;
            else begin m_t = i_seg_tens; m_o = i_seg_ones; m_run = 1; end
            if (m_run == N) m_dec = 1;
        end
    end

    always @(negedge i_clk) if (chk_en) begin
        chk("in_ready", o_in_ready, !(m_dec || m_hold));
        chk("out_valid", o_out_valid, m_hold);
        chk("err_count", o_err_count, m_ecnt);
        if (m_hold) begin
            chk("value", o_value, m_val);
            chk("err", o_err, m_err);
        end
    end

    task automatic step(input bit v, input logic [6:0] t, input logic [6:0] o, input bit r);
        i_in_valid = v; i_seg_tens = t; i_seg_ones = o; i_out_ready = r;
        @(posedge i_clk); #1;
    endtask

    task automatic run(input logic [6:0] t, input logic [6:0] o, input int ev, input int ee, input string nm);
        repeat (N) step(1, t, o, 0);
        step(0, 7'h7F, 7'h40, 0);
        chk({nm, "_ovalid"}, o_out_valid, 1);
        chk({nm, "_value"}, o_value, ev);
        chk({nm, "_err"}, o_err, ee);
        step(0, 7'h7F, 7'h40, 1);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_in_ready"}, o_in_ready, 1);
        chk({nm, "_out_valid"}, o_out_valid, 0);
        chk({nm, "_value"}, o_value, 0);
        chk({nm, "_err"}, o_err, 0);
        chk({nm, "_err_count"}, o_err_count, 0);
    endtask

    initial begin
        logic [6:0] rt, ro;
        i_reset = 1'b1;
        step(0, 7'h7F, 7'h40, 0);
        step(0, 7'h7F, 7'h40, 0);
        i_reset = 1'b0;
        chk_en = 1'b1;
        chk_reset_vals("rst");

        // Blank/0 with consumer always ready: result in cycle N+1, then IDLE.
        repeat (N) step(1, 7'h7F, 7'h40, 1);
        chk("t1_decode_busy", o_in_ready, 0);
        step(0, 7'h7F, 7'h40, 1);
        chk("t1_ovalid", o_out_valid, 1);
        chk("t1_value", o_value, 0);
        chk("t1_err", o_err, 0);
        step(0, 7'h7F, 7'h40, 1);
        chk("t1_idle_ready", o_in_ready, 1);
        chk("t1_idle_ovalid", o_out_valid, 0);

        // 15 held for 10 cycles with in_valid pulses ignored.
        repeat (N) step(1, 7'h79, 7'h12, 0);
        step(1, 7'h79, 7'h12, 0);
        for (int i = 0; i < 10; i++) begin
            chk("t2_hold_ovalid", o_out_valid, 1);
            chk("t2_hold_value", o_value, 15);
            chk("t2_hold_ready", o_in_ready, 0);
            step(i[0], 7'h79, 7'h12, 0);
        end
        step(1, 7'h79, 7'h12, 1);
        chk("t2_release", o_out_valid, 0);
        step(0, 7'h7F, 7'h40, 0);

        // Illegal pairs and saturation.
        run(7'h79, 7'h02, 0, 1, "t3_16");
        run(7'h00, 7'h40, 0, 1, "t3_tens");
        chk("t3_errcnt2", o_err_count, 2);
        for (int i = 0; i < 260; i++) run(7'h79, 7'h10, 0, 1, "t3_sat");
        chk("t3_errcnt_sat", o_err_count, 255);

        // Restart on mismatch at sample 2.
        step(1, 7'h7F, 7'h40, 0);
        step(1, 7'h7F, 7'h40, 0);
        repeat (4) step(1, 7'h7F, 7'h79, 0);
        chk("t4_c6_ovalid", o_out_valid, 0);
        step(0, 7'h7F, 7'h40, 0);
        chk("t4_c7_ovalid", o_out_valid, 1);
        chk("t4_c7_value", o_value, 1);
        step(0, 7'h7F, 7'h40, 1);
        // A gap drops the run: no result.
        step(1, 7'h7F, 7'h40, 1);
        step(1, 7'h7F, 7'h40, 1);
        step(0, 7'h7F, 7'h40, 1);
        repeat (3) step(1, 7'h7F, 7'h79, 1);
        step(0, 7'h7F, 7'h40, 1);
        step(0, 7'h7F, 7'h40, 1);
        chk("t4_gap_no_result", o_out_valid, 0);

        // Reset mid-FILTER and in HOLD.
        step(1, 7'h7F, 7'h24, 0);
        step(1, 7'h7F, 7'h24, 0);
        i_reset = 1'b1;
        step(1, 7'h7F, 7'h24, 0);
        i_reset = 1'b0;
        chk_reset_vals("t5_rst_filter");
        run(7'h79, 7'h00, 0, 1, "t5_mkerr");
        repeat (N) step(1, 7'h7F, 7'h24, 0);
        step(0, 7'h7F, 7'h40, 0);
        chk("t5_hold", o_out_valid, 1);
        i_reset = 1'b1;
        step(0, 7'h7F, 7'h40, 0);
        i_reset = 1'b0;
        chk_reset_vals("t5_rst_hold");
        run(7'h7F, 7'h24, 2, 0, "t5_fresh");

        // Random traffic, checked by the compare process.
        rt = 7'h7F; ro = 7'h40;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(3))
                    0: rt = 7'h7F;
                    1: rt = 7'h79;
                    2: rt = 7'h7F;
                    default: rt = 7'($urandom);
                endcase
                ro = ($urandom_range(7) == 0) ? 7'($urandom) : ONES[$urandom_range(9)];
            end
            i_reset = ($urandom_range(299) == 0);
            step($urandom_range(7) != 0, rt, ro, $urandom_range(2) != 0);
        end
        i_reset = 1'b0;
        step(0, 7'h7F, 7'h40, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/seg_pair_decoder.md
# seg_pair_decoder

Decodes the two-digit, active-low seven-segment pattern pair (tens digit, ones digit) that the display encoder path produces back into the 4-bit binary value 0–15. A glitch filter requires the pattern pair to stay stable before it is decoded. Illegal patterns are flagged and counted. The block sits on the self-check/loopback path: it takes display-bus patterns on a valid/ready input and delivers one registered result per stable sample run on a valid/ready output.

## Interface
- STABLE_CYCLES, default 4: consecutive identical accepted samples required before decode; legal range 1–15.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- seg_tens  input  7  tens-digit segments, bit 6..0 = G F E D C B A, active low (0 = lit).
- seg_ones  input  7  ones-digit segments, same bit order and polarity.
- in_valid  input  1  seg_tens/seg_ones carry a sample this cycle.
- in_ready  output  1  block accepts a sample this cycle; a sample is accepted when in_valid & in_ready.
- value  output  4  decoded binary value; meaningful while out_valid.
- err  output  1  the decoded pair was illegal; value is 0 when err is set.
- out_valid  output  1  result available; held until out_ready.
- out_ready  input  1  consumer takes the result when out_valid & out_ready.
- err_count  output  8  saturating count of err results delivered; stops at 255.

## Operation
- Ones-digit codes, hex, active low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. Any other code is illegal.
- Tens-digit codes: 7F = blank (tens 0), 79 = "1" (tens 1). Any other code is illegal.
- value = tens*10 + ones. Legal results are 0–15. Tens "1" with ones 6–9 (16–19) is illegal.
- Illegal result: err=1, value=0.
- FSM states: IDLE, FILTER, DECODE, HOLD.
- IDLE (in_ready=1): on an accepted sample, capture the pair into a holding register, set count=1, and go to FILTER. If STABLE_CYCLES=1, go to DECODE instead.
- FILTER (in_ready=1), one case per cycle:
  - Accepted sample equal to the held pair: count+1. When the count reaches STABLE_CYCLES, go to DECODE.
  - Accepted sample different from the held pair: recapture it, set count=1, stay in FILTER.
  - in_valid=0: discard the held pair, count=0, go to IDLE.
- DECODE (in_ready=0): register value and err from the held pair. If err, increment err_count (saturating). Go to HOLD.
- HOLD (in_ready=0, out_valid=1): value and err are stable. On out_ready, go to IDLE.
- A sample presented during DECODE or HOLD is not accepted and is not buffered. This includes a sample presented in the same cycle as the HOLD→IDLE transition.
- count width is 4 bits. It never exceeds STABLE_CYCLES.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, value=0, err=0, err_count=0, count=0, holding register=7F/40.
- Reset asserted in any state, including mid-FILTER or HOLD with out_valid high, returns all of the above on the next edge. The pending result is lost and err_count is cleared.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- Latency: number accepted samples from cycle 0. With N = STABLE_CYCLES identical samples in cycles 0..N-1, DECODE occupies cycle N and out_valid is first high in cycle N+1.
- A mismatch at sample k restarts the run. The earliest out_valid is then cycle k+N+1.
- Throughput: one result per N+2 cycles minimum. This includes the single IDLE cycle after the out_ready handshake.
- value, err and err_count update only on the DECODE→HOLD edge.

## Test plan
- Reset, then N=4 samples of tens 7F, ones 40 with out_ready=1: out_valid high in cycle 5, value=0, err=0, next cycle state IDLE.
- Samples of tens 79, ones 12 (15), held for 4 cycles, with out_ready held 0 for 10 cycles: value=F stays stable and out_valid stays high for all 10 cycles. in_ready=0 throughout, and in_valid pulses during HOLD are ignored.
- Tens 79, ones 02 (16), then tens 00, ones 40 (illegal tens): two results with err=1, value=0, and err_count=2. Drive 260 illegal results: err_count saturates at FF.
- Ones pattern 40,40,79,79,79,79 with tens 7F: the run restarts at the third sample and out_valid rises in cycle 7 with value=1. An in_valid gap at cycle 2 instead returns to IDLE and produces no result.
- Assert reset in cycle 2 of a FILTER run and in a HOLD cycle: all outputs return to their reset values on the next edge. A fresh 4-sample run of 7F/24 then yields value=2 with normal latency.
